// File: rtl/alu_mc_if.sv
// Request/response bundle between the datapath control FSM and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             Co;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, op, A, B, flush,
        input  in_ready, out_valid, res, res_hi, Co, zero, overflow
    );

    modport slave (
        input  in_valid, op, A, B, flush,
        output in_ready, out_valid, res, res_hi, Co, zero, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), all results
// registered and announced by a one-cycle out_valid pulse.
//
// state  | meaning
// S_IDLE | ready for a new op; single-cycle ops complete here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_mc_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // hi: accumulator high half (MUL) or partial remainder (DIV)
    // lo: multiplier being shifted out (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_co;
    logic             alu_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_df;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_quo_nx;

    logic             last_iter;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.Co        = co_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = (res_q == '0);

    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    // Single-cycle result and flags for the op presented on the bus
    always_comb begin
        sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
        dif_w   = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = bus.A[SHW-1:0];
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_NOR:  alu_res = ~(bus.A | bus.B);
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_co  = sum_w[WIDTH];
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_co  = dif_w[WIDTH];
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                          (dif_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
                alu_co  = dif_w[WIDTH];
            end
            OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
                alu_co  = dif_w[WIDTH];
            end
            OP_SRL:  alu_res = bus.B >> shamt;
            OP_SLL:  alu_res = bus.B << shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.B) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        mul_hi_nx  = mul_sum[WIDTH:1];
        mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};

        // Partial remainder never exceeds WIDTH bits, so the wrapped
        // WIDTH-bit difference is exact whenever the subtraction is taken.
        // A zero divisor always subtracts: quotient fills with ones and the
        // remainder collects the dividend unchanged.
        div_sh     = {hi_q, lo_q[WIDTH-1]};
        div_ok     = (div_sh >= {1'b0, opd_q});
        div_df     = div_sh[WIDTH-1:0] - opd_q;
        div_rem_nx = div_ok ? div_df : div_sh[WIDTH-1:0];
        div_quo_nx = {lo_q[WIDTH-2:0], div_ok};
    end

    // Next-state, iteration datapath and result register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opd_d       = opd_q;
        out_valid_d = 1'b0;
        res_d       = res_q;
        res_hi_d    = res_hi_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MULU) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = bus.B;
                        opd_d   = bus.A;
                    end else if (bus.op == OP_DIVU) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = bus.A;
                        opd_d   = bus.B;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = alu_res;
                        res_hi_d    = '0;
                        co_d        = alu_co;
                        ovf_d       = alu_ovf;
                    end
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = mul_hi_nx;
                    lo_d  = mul_lo_nx;
                    cnt_d = cnt_q + SHW'(1);
                    if (last_iter) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        res_d       = mul_lo_nx;
                        res_hi_d    = mul_hi_nx;
                        co_d        = 1'b0;
                        ovf_d       = 1'b0;
                    end
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = div_rem_nx;
                    lo_d  = div_quo_nx;
                    cnt_d = cnt_q + SHW'(1);
                    if (last_iter) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        res_d       = div_quo_nx;
                        res_hi_d    = div_rem_nx;
                        co_d        = 1'b0;
                        ovf_d       = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opd_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opd_q       <= opd_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the multi-cycle CPU datapath, successor to the single-cycle 32-bit ALU. It keeps the 3-bit operation set in compatible encodings, adds shifts, unsigned compare and iterative unsigned multiply/divide, and implements the signed overflow flag. All results are registered behind a valid/ready handshake so the control FSM can issue and wait on operations of any latency.

## Interface
- WIDTH, 32, operand/result width; ≥ 8, power of two
- SHW, $clog2(WIDTH), shift-amount bits taken from A
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; handshake fires when in_valid & in_ready at a rising edge
- op  in  4  operation code
- A  in  WIDTH  operand A (shift amount source for shifts)
- B  in  WIDTH  operand B (shifted value for shifts)
- flush  in  1  abort an in-flight multi-cycle op
- out_valid  out  1  one-cycle pulse: result registers updated
- res  out  WIDTH  primary result
- res_hi  out  WIDTH  MULU high word / DIVU remainder; 0 for other ops
- Co  out  1  carry-out of ADD; carry-out of A+~B+1 for SUB/SLT/SLTU (1 = no borrow)
- zero  out  1  res == 0
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise

## Operation
- Codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL (B >> A[SHW-1:0]), 6 SUB (A−B), 7 SLT signed, 8 SLL (B << A[SHW-1:0]), 9 SRA (B >>> A[SHW-1:0]), 10 SLTU, 11 MULU, 13 DIVU; 12, 14, 15 → res = 0, flags 0, single-cycle.
- All arithmetic modulo 2^WIDTH; shift amount uses only low SHW bits of A.
- Overflow: ADD = A,B same sign and sum sign differs; SUB = A,B sign differ and diff sign differs from A.
- FSM states: IDLE, MUL, DIV.
- IDLE: in_ready = 1. Handshake with a single-cycle op → result/flags registered at that edge, out_valid = 1 next cycle, stay IDLE. Handshake with MULU/DIVU → latch operands, clear counter, go MUL/DIV.
- MUL: shift-add, one bit of B per cycle, 2·WIDTH-bit accumulator; after WIDTH iterations res = product[WIDTH-1:0], res_hi = product[2·WIDTH-1:WIDTH], return IDLE.
- DIV: restoring division, one quotient bit per cycle; after WIDTH iterations res = A/B, res_hi = A%B. B = 0 → res = all ones, res_hi = A (still WIDTH cycles).
- MULU/DIVU: Co = overflow = 0; zero reflects res only.
- flush in MUL/DIV → IDLE at next edge, no out_valid, outputs keep previous values. flush in IDLE ignored; flush has priority over completion on the same edge.
- in_valid while in_ready = 0: ignored, not queued.
- res/res_hi/flags hold their value until the next out_valid.

## Timing
- Reset (async, rst_n low): FSM IDLE, in_ready = 1, out_valid = 0, res = res_hi = 0, Co = 0, overflow = 0, zero = 1, counter = 0. Reset mid-MUL/DIV discards the op.
- Single-cycle op accepted at edge k: out_valid high during cycle k→k+1; back-to-back accepts every cycle allowed.
- MULU/DIVU accepted at edge k: in_ready low from edge k; last iteration at edge k+WIDTH writes outputs, out_valid and in_ready high in cycle k+WIDTH→k+WIDTH+1 (latency WIDTH+1 cycles to visible result; next op can be accepted in the out_valid cycle).
- out_valid never high for more than one cycle per accepted op.

## Test plan
- Reset: rst_n low mid-cycle → in_ready = 1, out_valid = 0, res = 0, zero = 1 immediately, no clock needed.
- ALU sweep WIDTH = 32: ADD 0x7FFFFFFF+1 → res 0x80000000, overflow 1, Co 0; SUB 5−5 → res 0, zero 1, Co 1; SLT −1 vs 1 → 1; SLTU 0xFFFFFFFF vs 1 → 0; SRA A=4, B=0x80000000 → 0xF8000000; SRL A=36 (shift 4) → 0x08000000; each out_valid exactly one cycle after accept.
- MULU 0xFFFFFFFF×0xFFFFFFFF → res 0x00000001, res_hi 0xFFFFFFFE, out_valid 33 cycles after accept edge; in_valid pulses during busy ignored.
- DIVU 100/7 → res 14, res_hi 2; DIVU 9/0 → res 0xFFFFFFFF, res_hi 9; both 33-cycle latency.
- flush at iteration 10 of MULU → no out_valid, prior res unchanged, in_ready 1 next cycle; rst_n low at iteration 5 of DIVU → all outputs at reset values, new op accepted after release.
- Parameter WIDTH = 8: MULU 200×3 → res 0x58, res_hi 0x02, latency 9; ADD 0x7F+1 → overflow 1.
